// File: rtl/hoplite_packet_assembler.sv
// Stages per-field strobes into a flit, queues it in a small FIFO and hands the head to a Hoplite router.
// Optional PACKET_STATS_EN adds packets_sent / packets_dropped counters.
module hoplite_packet_assembler #(
    parameter int COORD_BITS           = 1,
    parameter int MULTICAST_GROUP_BITS = 1,
    parameter int MATRIX_TYPE_BITS     = 1,
    parameter int MATRIX_COORD_BITS    = 8,
    parameter int MATRIX_ELEMENT_BITS  = 32,
    parameter int FIFO_DEPTH           = 4,
    parameter int PACKET_BITS          = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                                         + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [COORD_BITS-1:0]           x_coord_in,
    input  logic                            x_coord_in_valid,
    input  logic [COORD_BITS-1:0]           y_coord_in,
    input  logic                            y_coord_in_valid,
    input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
    input  logic                            multicast_group_in_valid,
    input  logic                            done_flag_in,
    input  logic                            done_flag_in_valid,
    input  logic                            result_flag_in,
    input  logic                            result_flag_in_valid,
    input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
    input  logic                            matrix_type_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
    input  logic                            matrix_x_coord_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
    input  logic                            matrix_y_coord_in_valid,
    input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
    input  logic                            matrix_element_in_valid,
    input  logic                            packet_complete_in,
    output logic                            message_out_ready,
    output logic                            overflow,
`ifdef PACKET_STATS_EN
    output logic [31:0]                     packets_sent,
    output logic [31:0]                     packets_dropped,
`endif
    output logic [PACKET_BITS-1:0]          packet_out,
    output logic                            packet_out_valid,
    input  logic                            packet_out_ready
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [COORD_BITS-1:0]           r_x, r_y, w_x, w_y;
    logic [MULTICAST_GROUP_BITS-1:0] r_mcast, w_mcast;
    logic                            r_done, r_result, w_done, w_result;
    logic [MATRIX_TYPE_BITS-1:0]     r_type, w_type;
    logic [MATRIX_COORD_BITS-1:0]    r_mx, r_my, w_mx, w_my;
    logic [MATRIX_ELEMENT_BITS-1:0]  r_elem, w_elem;

    logic [PACKET_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic                   r_overflow;
    logic [PACKET_BITS-1:0] w_flit;
    logic                   w_empty, w_full, w_push, w_pop, w_drop;

    // Same-cycle strobes bypass the staging registers so they land in a flit pushed this cycle.
    assign w_x      = x_coord_in_valid         ? x_coord_in         : r_x;
    assign w_y      = y_coord_in_valid         ? y_coord_in         : r_y;
    assign w_mcast  = multicast_group_in_valid ? multicast_group_in : r_mcast;
    assign w_done   = done_flag_in_valid       ? done_flag_in       : r_done;
    assign w_result = result_flag_in_valid     ? result_flag_in     : r_result;
    assign w_type   = matrix_type_in_valid     ? matrix_type_in     : r_type;
    assign w_mx     = matrix_x_coord_in_valid  ? matrix_x_coord_in  : r_mx;
    assign w_my     = matrix_y_coord_in_valid  ? matrix_y_coord_in  : r_my;
    assign w_elem   = matrix_element_in_valid  ? matrix_element_in  : r_elem;

    assign w_flit = {w_elem, w_my, w_mx, w_type, w_result, w_done, w_mcast, w_y, w_x};

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_pop   = !w_empty && packet_out_ready;
    assign w_push  = packet_complete_in && (!w_full || w_pop);
    assign w_drop  = packet_complete_in && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_mcast  <= '0;
            r_done   <= 1'b0;
            r_result <= 1'b0;
            r_type   <= '0;
            r_mx     <= '0;
            r_my     <= '0;
            r_elem   <= '0;
        end else begin
            r_x      <= w_x;
            r_y      <= w_y;
            r_mcast  <= w_mcast;
            r_done   <= w_done;
            r_result <= w_result;
            r_type   <= w_type;
            r_mx     <= w_mx;
            r_my     <= w_my;
            r_elem   <= w_elem;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Storage is not reset; the empty flag masks stale entries on packet_out.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= w_flit;
    end

    assign packet_out        = w_empty ? '0 : r_mem[r_rd_ptr[IDX_W-1:0]];
    assign packet_out_valid  = !w_empty;
    assign message_out_ready = !w_full;
    assign overflow          = r_overflow;

`ifdef PACKET_STATS_EN
    logic [31:0] r_sent, r_dropped;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sent    <= '0;
            r_dropped <= '0;
        end else begin
            if (w_pop)  r_sent    <= r_sent + 32'd1;
            if (w_drop) r_dropped <= r_dropped + 32'd1;
        end
    end

    assign packets_sent    = r_sent;
    assign packets_dropped = r_dropped;
`endif

endmodule

// File: tb/tb_hoplite_packet_assembler.sv
// Randomized + directed bench for hoplite_packet_assembler against a queue-based reference model.
module tb_hoplite_packet_assembler;

    localparam int CB = 1, MB = 1, TB = 1, MCB = 8, EB = 32, DEPTH = 4;
    localparam int PB = 2*CB + MB + 2 + TB + 2*MCB + EB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CB-1:0]  x_in, y_in;
    logic           x_v, y_v, mc_v, dn_v, rs_v, ty_v, mx_v, my_v, el_v;
    logic [MB-1:0]  mc_in;
    logic           dn_in, rs_in;
    logic [TB-1:0]  ty_in;
    logic [MCB-1:0] mx_in, my_in;
    logic [EB-1:0]  el_in;
    logic           complete, ready;
    logic           message_out_ready, overflow, packet_out_valid;
    logic [PB-1:0]  packet_out;
`ifdef PACKET_STATS_EN
    logic [31:0]    packets_sent, packets_dropped;
`endif

    hoplite_packet_assembler #(
        .COORD_BITS(CB), .MULTICAST_GROUP_BITS(MB), .MATRIX_TYPE_BITS(TB),
        .MATRIX_COORD_BITS(MCB), .MATRIX_ELEMENT_BITS(EB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .x_coord_in(x_in), .x_coord_in_valid(x_v),
        .y_coord_in(y_in), .y_coord_in_valid(y_v),
        .multicast_group_in(mc_in), .multicast_group_in_valid(mc_v),
        .done_flag_in(dn_in), .done_flag_in_valid(dn_v),
        .result_flag_in(rs_in), .result_flag_in_valid(rs_v),
        .matrix_type_in(ty_in), .matrix_type_in_valid(ty_v),
        .matrix_x_coord_in(mx_in), .matrix_x_coord_in_valid(mx_v),
        .matrix_y_coord_in(my_in), .matrix_y_coord_in_valid(my_v),
        .matrix_element_in(el_in), .matrix_element_in_valid(el_v),
        .packet_complete_in(complete),
        .message_out_ready(message_out_ready),
        .overflow(overflow),
`ifdef PACKET_STATS_EN
        .packets_sent(packets_sent),
        .packets_dropped(packets_dropped),
`endif
        .packet_out(packet_out),
        .packet_out_valid(packet_out_valid),
        .packet_out_ready(ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: field values, packet queue, sticky flag, counters.
    logic [63:0] m_x, m_y, m_mc, m_dn, m_rs, m_ty, m_mx, m_my, m_el;
    logic [PB-1:0] m_q[$];
    logic        m_ov;
    int unsigned m_sent, m_drop;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flit built by weighted sum: each field sits above the total width of the ones before it.
    function automatic logic [PB-1:0] pack_flit();
        logic [63:0] v;
        int off;
        v = 0; off = 0;
        v += m_x  << off; off += CB;
        v += m_y  << off; off += CB;
        v += m_mc << off; off += MB;
        v += m_dn << off; off += 1;
        v += m_rs << off; off += 1;
        v += m_ty << off; off += TB;
        v += m_mx << off; off += MCB;
        v += m_my << off; off += MCB;
        v += m_el << off;
        return v[PB-1:0];
    endfunction

    task automatic clr_in();
        {x_v, y_v, mc_v, dn_v, rs_v, ty_v, mx_v, my_v, el_v, complete} = '0;
    endtask

    task automatic model_reset();
        {m_x, m_y, m_mc, m_dn, m_rs, m_ty, m_mx, m_my, m_el} = '0;
        m_q.delete();
        m_ov = 1'b0;
        m_sent = 0;
        m_drop = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk_val({tag, ".valid"}, 64'(packet_out_valid), 64'(m_q.size() != 0));
        chk_val({tag, ".data"},  64'(packet_out), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
        chk_val({tag, ".mready"}, 64'(message_out_ready), 64'(m_q.size() < DEPTH));
        chk_val({tag, ".ovf"}, 64'(overflow), 64'(m_ov));
`ifdef PACKET_STATS_EN
        chk_val({tag, ".sent"}, 64'(packets_sent), 64'(m_sent));
        chk_val({tag, ".dropped"}, 64'(packets_dropped), 64'(m_drop));
`endif
    endtask

    // Advance one clock: update the model from the current inputs, then compare after the edge.
    task automatic tick(input string tag);
        bit pop, push, drop;
        if (x_v)  m_x  = 64'(x_in);
        if (y_v)  m_y  = 64'(y_in);
        if (mc_v) m_mc = 64'(mc_in);
        if (dn_v) m_dn = 64'(dn_in);
        if (rs_v) m_rs = 64'(rs_in);
        if (ty_v) m_ty = 64'(ty_in);
        if (mx_v) m_mx = 64'(mx_in);
        if (my_v) m_my = 64'(my_in);
        if (el_v) m_el = 64'(el_in);
        pop  = (m_q.size() > 0) && ready;
        push = complete && ((m_q.size() < DEPTH) || pop);
        drop = complete && !push;
        if (pop) begin
            void'(m_q.pop_front());
            m_sent++;
        end
        if (push) m_q.push_back(pack_flit());
        if (drop) begin
            m_ov = 1'b1;
            m_drop++;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        clr_in();
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #2;
        check_outputs(tag);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic push_only(input string tag);
        complete = 1'b1;
        tick(tag);
    endtask

    initial begin
        clr_in();
        ready = 1'b0;
        {x_in, y_in, mc_in, dn_in, rs_in, ty_in, mx_in, my_in, el_in} = '0;
        model_reset();
        #3;
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Default field pattern, then push and pop.
        x_in = 1; y_in = 0; mc_in = 1; dn_in = 0; rs_in = 1; ty_in = 1;
        mx_in = 8'h12; my_in = 8'h34; el_in = 32'hDEADBEEF;
        {x_v, y_v, mc_v, dn_v, rs_v, ty_v, mx_v, my_v, el_v} = '1;
        tick("stage");
        ready = 1'b1;
        push_only("push1");
        chk_val("flit_default", 64'(packet_out), 64'h37AB6FBBCD04B5);
        chk_val("flit_default_vld", 64'(packet_out_valid), 64'd1);
        tick("pop1");
        chk_val("pop1_empty", 64'(packet_out_valid), 64'd0);

        // Fill with ready low, then overflow; each flit tagged by its element.
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            el_in = 32'h100 + 32'(i); el_v = 1'b1;
            push_only("fill");
        end
        chk_val("full_mready", 64'(message_out_ready), 64'd0);
        el_in = 32'h1FF; el_v = 1'b1;
        push_only("ovf_push");
        chk_val("ovf_set", 64'(overflow), 64'd1);
        chk_val("ovf_head", 64'(packet_out[PB-1 -: EB]), 64'h100);
        ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk_val("drain_order", 64'(packet_out[PB-1 -: EB]), 64'h100 + 64'(i));
            tick("drain");
        end

        // Same-cycle element strobe is bypassed and then persists.
        ready = 1'b0;
        el_in = 32'h5; el_v = 1'b1;
        push_only("bypass");
        push_only("persist");
        chk_val("bypass_elem", 64'(packet_out[PB-1 -: EB]), 64'h5);
        ready = 1'b1;
        tick("bp_pop");
        chk_val("persist_elem", 64'(packet_out[PB-1 -: EB]), 64'h5);
        tick("bp_pop2");

        // Full FIFO with simultaneous push and pop: push accepted, still full.
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_only("fill2");
        el_in = 32'hABC; el_v = 1'b1; ready = 1'b1;
        push_only("full_pushpop");
        chk_val("fpp_mready", 64'(message_out_ready), 64'd0);
        chk_val("fpp_qsize", 64'(m_q.size()), 64'(DEPTH));
        ready = 1'b0;
        tick("fpp_hold");

        // Reset with three queued packets.
        async_reset("rst_q0");
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_only("q3");
        async_reset("rst_mid");
        chk_val("rst_mid_vld", 64'(packet_out_valid), 64'd0);
        chk_val("rst_mid_mready", 64'(message_out_ready), 64'd1);
        @(posedge clk); #1;

`ifdef PACKET_STATS_EN
        for (int i = 0; i < 6; i++) push_only("st_push");
        ready = 1'b1;
        for (int i = 0; i < 4; i++) tick("st_pop");
        chk_val("stat_sent", 64'(packets_sent), 64'd4);
        chk_val("stat_dropped", 64'(packets_dropped), 64'd2);
        ready = 1'b0;
`endif

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            x_in  = CB'($urandom);  x_v  = ($urandom_range(0, 3) == 0);
            y_in  = CB'($urandom);  y_v  = ($urandom_range(0, 3) == 0);
            mc_in = MB'($urandom);  mc_v = ($urandom_range(0, 3) == 0);
            dn_in = 1'($urandom);   dn_v = ($urandom_range(0, 3) == 0);
            rs_in = 1'($urandom);   rs_v = ($urandom_range(0, 3) == 0);
            ty_in = TB'($urandom);  ty_v = ($urandom_range(0, 3) == 0);
            mx_in = MCB'($urandom); mx_v = ($urandom_range(0, 3) == 0);
            my_in = MCB'($urandom); my_v = ($urandom_range(0, 3) == 0);
            el_in = $urandom;       el_v = ($urandom_range(0, 3) == 0);
            complete = ($urandom_range(0, 9) < 5);
            ready    = ($urandom_range(0, 9) < 4);
            tick("rand");
            if (c == 1000) begin
                async_reset("rand_rst");
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hoplite_packet_assembler.md
# hoplite_packet_assembler

- Sits between the processing node's memory-mapped network outputs and the Hoplite router injection port.
- Captures the per-field strobes (coordinates, multicast group, flags, matrix type/coords/element) into staging registers.
- On the packet-complete pulse, concatenates the staged fields into one flit and pushes it into a small FIFO.
- Presents the FIFO head to the router with a valid/ready handshake, and drives the `message_out_ready` status the node's firmware polls before building a packet.

## Interface
Parameters:
- `COORD_BITS`, 1: router X/Y coordinate width.
- `MULTICAST_GROUP_BITS`, 1: multicast group width.
- `MATRIX_TYPE_BITS`, 1: matrix type width.
- `MATRIX_COORD_BITS`, 8: matrix x/y coordinate width.
- `MATRIX_ELEMENT_BITS`, 32: element width.
- `FIFO_DEPTH`, 4: packet FIFO entries; power of two, ≥2.
- `PACKET_BITS`, 2*COORD_BITS+MULTICAST_GROUP_BITS+2+MATRIX_TYPE_BITS+2*MATRIX_COORD_BITS+MATRIX_ELEMENT_BITS: derived flit width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `reset_n` in 1: reset.
- Field inputs, each a value/strobe pair:
  - `x_coord_in` / `x_coord_in_valid` in COORD_BITS/1.
  - `y_coord_in` / `y_coord_in_valid` in COORD_BITS/1.
  - `multicast_group_in` / `multicast_group_in_valid` in MULTICAST_GROUP_BITS/1.
  - `done_flag_in` / `done_flag_in_valid` in 1/1.
  - `result_flag_in` / `result_flag_in_valid` in 1/1.
  - `matrix_type_in` / `matrix_type_in_valid` in MATRIX_TYPE_BITS/1.
  - `matrix_x_coord_in` / `matrix_x_coord_in_valid` in MATRIX_COORD_BITS/1.
  - `matrix_y_coord_in` / `matrix_y_coord_in_valid` in MATRIX_COORD_BITS/1.
  - `matrix_element_in` / `matrix_element_in_valid` in MATRIX_ELEMENT_BITS/1.
- Control and status:
  - `packet_complete_in` in 1: single-cycle pulse; push the staged packet.
  - `message_out_ready` out 1: FIFO not full.
  - `overflow` out 1: sticky; a packet was dropped.
- Router side:
  - `packet_out` out PACKET_BITS: FIFO head flit.
  - `packet_out_valid` out 1: FIFO non-empty.
  - `packet_out_ready` in 1: router accepts head this cycle.

## Operation
- Flit layout, LSB first: x, y, multicast_group, done_flag, result_flag, matrix_type, matrix_x, matrix_y, matrix_element.
- Staging: each field register loads on its strobe and holds otherwise. Fields persist across packets: firmware rewrites only what changes.
- Push: on `packet_complete_in` with FIFO not full, write the flit into the entry at the write pointer.
  - A field strobe in the same cycle as `packet_complete_in` is bypassed into the pushed flit.
- Drop: on `packet_complete_in` with FIFO full and no same-cycle pop, the packet is discarded and `overflow` sets. `overflow` clears only on reset.
- Pop: `packet_out_valid && packet_out_ready` advances the read pointer.
- Push and pop in the same cycle are both performed; this holds even when full, in which case the push is accepted.
- Pointers are log2(FIFO_DEPTH)+1 bits; indices wrap modulo FIFO_DEPTH.
  - Empty: pointers equal.
  - Full: MSBs differ, remaining bits equal.
- `packet_out` is the entry at the read pointer, forced to 0 when empty.
- `packet_out_valid` = !empty.
- `message_out_ready` = !full.
- Narrow input values are taken from the LSBs of the field inputs; there is no arithmetic on field values.

## Timing
- Reset (asynchronous, immediate):
  - staging registers 0; pointers 0.
  - `packet_out` 0, `packet_out_valid` 0.
  - `message_out_ready` 1, `overflow` 0.
- Latency: push at rising edge N gives `packet_out_valid` high from N+1 when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- `packet_out` is stable while valid and not accepted.
- `message_out_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- Reset asserted mid-operation flushes all queued packets. No partial flit is emitted.

## Configuration
- `PACKET_STATS_EN` defined:
  - Adds output `packets_sent` (32 bits), counting accepted pops.
  - Adds output `packets_dropped` (32 bits), counting dropped pushes.
  - Both reset to 0 and wrap at 2^32.
- `PACKET_STATS_EN` undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Stage fields (defaults: x=1, y=0, mcast=1, done=0, result=1, type=1, mx=0x12, my=0x34, element 0xDEADBEEF), pulse complete with ready=1 → next cycle valid=1 with packet_out equal to the concatenation; pop → valid=0.
- With ready=0, push FIFO_DEPTH packets → `message_out_ready`=0 after the last push; a fifth push sets `overflow`=1, head unchanged; drain shows the first four in order.
- Element strobe 0x5 in the same cycle as complete → pushed flit carries 0x5; the next packet without rewrite also carries 0x5.
- Full FIFO, complete and pop in the same cycle → no overflow; count stays full; the new flit appears last.
- Reset pulsed with 3 queued packets → valid=0 and `packet_out`=0 immediately; `message_out_ready`=1.
- With `PACKET_STATS_EN`: 6 pushes into depth 4, 4 pops → `packets_sent`=4, `packets_dropped`=2.
